// File: rtl/arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBusyIf,
      StBusyDm,
      StDone
   } arb_state_e;

   localparam int unsigned MemLatMin = 1;
   localparam int unsigned MemLatMax = 7;
   localparam int unsigned CntW      = 3;

   function automatic logic lat_ok(input int unsigned lat);
      return (lat >= MemLatMin) && (lat <= MemLatMax);
   endfunction

endpackage

// File: rtl/arb_perf_counter.sv
// Free-running enabled counter that wraps at 2^Width.
module arb_perf_counter #(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [Width-1:0] count
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (en) begin
         count_d = count_q + Width'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-port fixed-latency memory between fetch and memory stages.
// Optional performance counters are enabled with the ARB_PERF_CNT_EN macro.
module unified_mem_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   input  logic              pcsrce,
   output logic              stallf,
   output logic              stallm,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,output logic [31:0]       perf_stallf_cnt,
   output logic [31:0]       perf_conflict_cnt
`endif
);

   if (!lat_ok(MEM_LAT)) begin : g_lat_chk
      $error("MEM_LAT out of range 1..7");
   end

   localparam logic [CntW-1:0] LatCnt = CntW'(MEM_LAT);

   arb_state_e        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              kill_q, kill_d;
   logic              fair_q, fair_d;
   logic              dm_we_q, dm_we_d;
   logic              if_valid_q, if_valid_d;
   logic              dm_valid_q, dm_valid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

   logic if_elig, dm_elig, idle, grant_if, grant_dm, lat_hit;

   // A fetch whose PC is being redirected this cycle is stale and not eligible.
   assign if_elig  = if_req & ~pcsrce;
   assign dm_elig  = dm_req;
   assign idle     = (state_q == StIdle) & rst;
   assign grant_dm = idle & dm_elig & ~(if_elig & fair_q);
   assign grant_if = idle & if_elig & ~grant_dm;
   assign lat_hit  = (cnt_q == LatCnt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kill_d  = kill_q;
      fair_d  = fair_q;
      unique case (state_q)
         StIdle: begin
            if (grant_dm) begin
               state_d = StBusyDm;
               cnt_d   = CntW'(1);
               fair_d  = if_req;
            end else if (grant_if) begin
               state_d = StBusyIf;
               cnt_d   = CntW'(1);
               fair_d  = 1'b0;
            end
         end
         StBusyIf: begin
            cnt_d = cnt_q + CntW'(1);
            if (pcsrce) begin
               kill_d = 1'b1;
            end
            if (lat_hit) begin
               state_d = StDone;
            end
         end
         StBusyDm: begin
            cnt_d = cnt_q + CntW'(1);
            if (lat_hit) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
            cnt_d   = '0;
            kill_d  = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_req    = grant_dm | grant_if;
      mem_we     = grant_dm & dm_we;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (grant_dm) begin
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (grant_if) begin
         mem_addr  = if_addr;
      end
      dm_we_d    = grant_dm ? dm_we : dm_we_q;
      // A redirect in the capture cycle itself must also suppress the fetch.
      if_valid_d = (state_q == StBusyIf) & lat_hit & ~kill_q & ~pcsrce;
      dm_valid_d = (state_q == StBusyDm) & lat_hit;
      if_rdata_d = if_valid_d ? mem_rdata : if_rdata_q;
      dm_rdata_d = (dm_valid_d & ~dm_we_q) ? mem_rdata : dm_rdata_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= '0;
         kill_q     <= 1'b0;
         fair_q     <= 1'b0;
         dm_we_q    <= 1'b0;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         kill_q     <= kill_d;
         fair_q     <= fair_d;
         dm_we_q    <= dm_we_d;
         if_valid_q <= if_valid_d;
         dm_valid_q <= dm_valid_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   assign if_valid = if_valid_q;
   assign dm_valid = dm_valid_q;
   assign if_rdata = if_rdata_q;
   assign dm_rdata = dm_rdata_q;
   assign stallf   = if_req & ~if_valid_q;
   assign stallm   = dm_req & ~dm_valid_q;

`ifdef ARB_PERF_CNT_EN
   logic conflict;

   assign conflict = (state_q == StIdle) & if_elig & dm_elig;

   arb_perf_counter #(.Width(32)) u_perf_stallf (
      .clk   (clk),
      .rst   (rst),
      .en    (stallf),
      .count (perf_stallf_cnt)
   );

   arb_perf_counter #(.Width(32)) u_perf_conflict (
      .clk   (clk),
      .rst   (rst),
      .en    (conflict),
      .count (perf_conflict_cnt)
   );
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed, table-driven bench for unified_mem_arbiter with MEM_LAT = 2.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_we, pcsrce;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_valid, dm_valid, stallf, stallm, mem_req, mem_we;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_stallf_cnt, perf_conflict_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_valid  (dm_valid),
      .pcsrce    (pcsrce),
      .stallf    (stallf),
      .stallm    (stallm),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef ARB_PERF_CNT_EN
     ,.perf_stallf_cnt   (perf_stallf_cnt),
      .perf_conflict_cnt (perf_conflict_cnt)
`endif
   );

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] dd;
      logic        pc;
      logic [31:0] mr;
      logic        mq;
      logic        mw;
      logic [31:0] ma;
      logic [31:0] md;
      logic        iv;
      logic [31:0] id;
      logic        dv;
      logic [31:0] dmr;
      logic        sf;
      logic        sm;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t row(
      input int unsigned ir, ia, dr, dw, da, dd, pc, mr,
      input int unsigned mq, mw, ma, md, iv, id, dv, dmr, sf, sm);
      vec_t v;
      v.ir = (ir != 0); v.ia = ia; v.dr = (dr != 0); v.dw = (dw != 0);
      v.da = da; v.dd = dd; v.pc = (pc != 0); v.mr = mr;
      v.mq = (mq != 0); v.mw = (mw != 0); v.ma = ma; v.md = md;
      v.iv = (iv != 0); v.id = id; v.dv = (dv != 0); v.dmr = dmr;
      v.sf = (sf != 0); v.sm = (sm != 0);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   localparam int unsigned IA = 'h00500093;
   localparam int unsigned DB = 'hDEADBEEF;
   localparam int unsigned IB = 'h00A00113;
   localparam int unsigned IN = 'h00000013;
   localparam int unsigned IC = 'h00000033;
   localparam int unsigned SD = 'h12345678;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      int   g;
      logic stale;
      logic kind[3];
      int   at[3];

      rst = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; pcsrce = 0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

      // Columns: if_req if_addr dm_req dm_we dm_addr dm_wdata pcsrce mem_rdata |
      //          mem_req mem_we mem_addr mem_wdata if_valid if_rdata dm_valid dm_rdata stallf stallm
      // Fetch only
      vecs.push_back(row(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(row(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(row(1, 0, 0, 0, 0, 0, 0, IA,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(row(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, IA, 0, 0, 0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, IA, 0, 0, 0, 0));
      // Conflict: DM first, then IF
      vecs.push_back(row(1, 4, 1, 0, 'h100, 0, 0, 0,  1, 0, 'h100, 0, 0, IA, 0, 0, 1, 1));
      vecs.push_back(row(1, 4, 1, 0, 'h100, 0, 0, 0,  0, 0, 0, 0, 0, IA, 0, 0, 1, 1));
      vecs.push_back(row(1, 4, 1, 0, 'h100, 0, 0, DB, 0, 0, 0, 0, 0, IA, 0, 0, 1, 1));
      vecs.push_back(row(1, 4, 1, 0, 'h100, 0, 0, 0,  0, 0, 0, 0, 0, IA, 1, DB, 1, 0));
      vecs.push_back(row(1, 4, 0, 0, 0, 0, 0, 0,      1, 0, 4, 0, 0, IA, 0, DB, 1, 0));
      vecs.push_back(row(1, 4, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, IA, 0, DB, 1, 0));
      vecs.push_back(row(1, 4, 0, 0, 0, 0, 0, IB,     0, 0, 0, 0, 0, IA, 0, DB, 1, 0));
      vecs.push_back(row(1, 4, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 1, IB, 0, DB, 0, 0));
      // Store: dm_rdata must keep the earlier load value
      vecs.push_back(row(0, 0, 1, 1, 'h40, SD, 0, 0,  1, 1, 'h40, SD, 0, IB, 0, DB, 0, 1));
      vecs.push_back(row(0, 0, 1, 1, 'h40, SD, 0, 0,  0, 0, 0, 0, 0, IB, 0, DB, 0, 1));
      vecs.push_back(row(0, 0, 1, 1, 'h40, SD, 0, 'hFFFFFFFF,
                         0, 0, 0, 0, 0, IB, 0, DB, 0, 1));
      vecs.push_back(row(0, 0, 1, 1, 'h40, SD, 0, 0,  0, 0, 0, 0, 0, IB, 1, DB, 0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, IB, 0, DB, 0, 0));
      // Flush: redirect kills the fetch, redirected fetch granted 4 cycles after the first
      vecs.push_back(row(1, 8, 0, 0, 0, 0, 0, 0,      1, 0, 8, 0, 0, IB, 0, DB, 1, 0));
      vecs.push_back(row(1, 'h200, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, IB, 0, DB, 1, 0));
      vecs.push_back(row(1, 'h200, 0, 0, 0, 0, 0, 'hBAD0BAD0,
                         0, 0, 0, 0, 0, IB, 0, DB, 1, 0));
      vecs.push_back(row(1, 'h200, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, IB, 0, DB, 1, 0));
      vecs.push_back(row(1, 'h200, 0, 0, 0, 0, 0, 0,  1, 0, 'h200, 0, 0, IB, 0, DB, 1, 0));
      vecs.push_back(row(1, 'h200, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, IB, 0, DB, 1, 0));
      vecs.push_back(row(1, 'h200, 0, 0, 0, 0, 0, IN, 0, 0, 0, 0, 0, IB, 0, DB, 1, 0));
      vecs.push_back(row(1, 'h200, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, IN, 0, DB, 0, 0));
      // Redirect in IDLE blocks the grant for that cycle
      vecs.push_back(row(1, 'h204, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, IN, 0, DB, 1, 0));
      vecs.push_back(row(1, 'h204, 0, 0, 0, 0, 0, 0,  1, 0, 'h204, 0, 0, IN, 0, DB, 1, 0));
      vecs.push_back(row(1, 'h204, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, IN, 0, DB, 1, 0));
      vecs.push_back(row(1, 'h204, 0, 0, 0, 0, 0, IC, 0, 0, 0, 0, 0, IN, 0, DB, 1, 0));
      vecs.push_back(row(1, 'h204, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, IC, 0, DB, 0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, IC, 0, DB, 0, 0));

      #2;
      check("rst mem_req",   {31'd0, mem_req},  32'd0);
      check("rst mem_we",    {31'd0, mem_we},   32'd0);
      check("rst mem_addr",  mem_addr,          32'd0);
      check("rst mem_wdata", mem_wdata,         32'd0);
      check("rst if_valid",  {31'd0, if_valid}, 32'd0);
      check("rst dm_valid",  {31'd0, dm_valid}, 32'd0);
      check("rst if_rdata",  if_rdata,          32'd0);
      check("rst dm_rdata",  dm_rdata,          32'd0);
      check("rst stallf",    {31'd0, stallf},   32'd0);
      check("rst stallm",    {31'd0, stallm},   32'd0);

      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         if_req = vecs[i].ir; if_addr = vecs[i].ia; dm_req = vecs[i].dr; dm_we = vecs[i].dw;
         dm_addr = vecs[i].da; dm_wdata = vecs[i].dd; pcsrce = vecs[i].pc;
         mem_rdata = vecs[i].mr;
         @(negedge clk);
         check($sformatf("row%0d mem_req", i),   {31'd0, mem_req},  {31'd0, vecs[i].mq});
         check($sformatf("row%0d mem_we", i),    {31'd0, mem_we},   {31'd0, vecs[i].mw});
         check($sformatf("row%0d mem_addr", i),  mem_addr,          vecs[i].ma);
         check($sformatf("row%0d mem_wdata", i), mem_wdata,         vecs[i].md);
         check($sformatf("row%0d if_valid", i),  {31'd0, if_valid}, {31'd0, vecs[i].iv});
         check($sformatf("row%0d if_rdata", i),  if_rdata,          vecs[i].id);
         check($sformatf("row%0d dm_valid", i),  {31'd0, dm_valid}, {31'd0, vecs[i].dv});
         check($sformatf("row%0d dm_rdata", i),  dm_rdata,          vecs[i].dmr);
         check($sformatf("row%0d stallf", i),    {31'd0, stallf},   {31'd0, vecs[i].sf});
         check($sformatf("row%0d stallm", i),    {31'd0, stallm},   {31'd0, vecs[i].sm});
      end

      // Asynchronous reset in the middle of a load
      @(posedge clk);
      #1;
      if_req = 0; pcsrce = 0; dm_req = 1; dm_we = 0; dm_addr = 'h300; mem_rdata = 'h55AA55AA;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("midrst mem_req",   {31'd0, mem_req},  32'd0);
      check("midrst mem_we",    {31'd0, mem_we},   32'd0);
      check("midrst mem_addr",  mem_addr,          32'd0);
      check("midrst mem_wdata", mem_wdata,         32'd0);
      check("midrst if_valid",  {31'd0, if_valid}, 32'd0);
      check("midrst dm_valid",  {31'd0, dm_valid}, 32'd0);
      check("midrst if_rdata",  if_rdata,          32'd0);
      check("midrst dm_rdata",  dm_rdata,          32'd0);
      dm_req = 0;
      @(negedge clk);
      rst = 1'b1;

      // Fresh fetch after reset must complete normally with no stale dm_valid
      @(posedge clk);
      #1;
      if_req = 1; if_addr = 'h10; mem_rdata = 'h0000A0B7;
      lat = -1;
      stale = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (dm_valid) stale = 1'b1;
         if (if_valid) begin
            lat = n;
            break;
         end
      end
      check("postrst fetch latency", lat, 32'd3);
      check("postrst if_rdata", if_rdata, 32'h0000A0B7);
      check("postrst stale dm_valid", {31'd0, stale}, 32'd0);

      // Fairness: both requesters held continuously
      @(posedge clk);
      #1;
      if_req = 1; if_addr = 'h20; dm_req = 1; dm_we = 0; dm_addr = 'h400; mem_rdata = 'h77;
      g = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (mem_req && g < 3) begin
            kind[g] = (mem_addr == 32'h400);
            at[g]   = n;
            g++;
         end
         if (g == 3) break;
      end
      check("fair grants seen", g, 32'd3);
      if (g == 3) begin
         check("fair grant0 is DM", {31'd0, kind[0]}, 32'd1);
         check("fair grant1 is IF", {31'd0, kind[1]}, 32'd0);
         check("fair grant2 is DM", {31'd0, kind[2]}, 32'd1);
         check("fair grant0 cycle", at[0], 32'd0);
         check("fair grant1 cycle", at[1], 32'd4);
         check("fair grant2 cycle", at[2], 32'd8);
      end
      @(posedge clk);
      #1;
      if_req = 0; dm_req = 0;
      repeat (4) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
